// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared widths, op codes and state encoding for the multiply/divide unit
package mdu_pkg;
    localparam int WIDTH = 32;
    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] res
);
    assign res = neg ? (~val + WIDTH'(1)) : val;
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-cycle shift-add multiplier / restoring divider with HI/LO
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam logic [5:0] LAST = 6'(ITERS - 1);

    mdu_state_e       state, state_nxt;
    logic [5:0]       count;
    logic             div_q, q_neg, r_neg, done_q;
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo, hi_q, lo_q;
    logic [WIDTH-1:0] mag_a, mag_b, hi_pre, hi_res, lo_res;
    logic             sgn_in, q_neg_in, hi_inv, hi_neg;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    assign sgn_in   = op_is_signed(op);
    // Divide by zero keeps quotient at all-ones, so its sign must not flip it.
    assign q_neg_in = sgn_in & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1])
                      & ~(op_is_div(op) & (rt_val == '0));

    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.neg(sgn_in & rs_val[WIDTH-1]), .val(rs_val), .res(mag_a));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.neg(sgn_in & rt_val[WIDTH-1]), .val(rt_val), .res(mag_b));

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd;

    // 64-bit negate split in halves: upper half is ~hi unless the low half is zero.
    assign hi_inv = ~div_q & q_neg & (acc_lo != '0);
    assign hi_pre = hi_inv ? ~acc_hi : acc_hi;
    assign hi_neg = div_q ? r_neg : (q_neg & ~hi_inv);

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_hi (.neg(hi_neg), .val(hi_pre), .res(hi_res));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_lo (.neg(q_neg), .val(acc_lo), .res(lo_res));

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (count == LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            div_q  <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    count  <= '0;
                    div_q  <= op_is_div(op);
                    q_neg  <= q_neg_in;
                    r_neg  <= sgn_in & rs_val[WIDTH-1];
                    opnd   <= op_is_div(op) ? mag_b : mag_a;
                    acc_lo <= op_is_div(op) ? mag_a : mag_b;
                    acc_hi <= '0;
                end
                ST_RUN: begin
                    count <= count + 6'd1;
                    if (div_q) begin
                        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    hi_q   <= hi_res;
                    lo_q   <= lo_res;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    int   d0;
    logic prev_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_seen++;
            chk("done_width", {63'd0, prev_done}, 64'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
                chk({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
                chk({e.name, "_latency"}, 64'(cyc - e.cyc), 64'd33);
            end
        end
        prev_done <= done;
    end

    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clock);
        #1;
        sb.push_back('{name: name, hi: eh, lo: el, cyc: cyc});
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: no done within 100 cycles", name);
        end
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        wait_done(name);
        issue(name, o, a, b, eh, el);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        issue("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("mult_neg3x7",  MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("div_neg7by2",  MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_minby_m1", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run("divu_by0",     MDU_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
        run("div_neg_by0",  MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run("mult_min_sq",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run("mult_7xm1",    MDU_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run("div_7bym2",    MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run("multu_2p32",   MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        run("mult_0xm1",    MDU_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);

        // ignored start while busy, then back-to-back start in the done cycle
        run("divu_100by7",  MDU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
        repeat (5) @(negedge clock);
        chk("busy_mid_run", {63'd0, busy}, 64'd1);
        start = 1'b1; op = MDU_MULTU; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clock);
        start = 1'b0;
        run("multu_2x3",    MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
        wait_done("multu_2x3");

        // reset mid-operation aborts without a done pulse
        start = 1'b1; op = MDU_MULT; rs_val = 32'd5; rt_val = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        d0 = done_seen;
        repeat (40) @(negedge clock);
        chk("abort_no_done", 64'(done_seen - d0), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 SHALL have port start  input  1  request to begin an operation; accepted only when busy=0.
REQ-005 SHALL have port op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port rs_val  input  32  first operand (multiplicand/dividend).
REQ-007 SHALL have port rt_val  input  32  second operand (multiplier/divisor).
REQ-008 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when HI/LO have been updated.
REQ-010 SHALL have port hi  output  32  HI register (MFHI source): product[63:32] or remainder.
REQ-011 SHALL have port lo  output  32  LO register (MFLO source): product[31:0] or quotient.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; IDLE->RUN on start at busy=0, RUN->FIX after 32nd iteration, FIX->IDLE unconditionally.
REQ-013 SHALL, at the accepting edge E0, latch op and operand magnitudes (absolute value for signed ops, raw for unsigned), record result signs, clear iteration counter to 0.
REQ-014 SHALL perform one iteration per cycle in RUN at edges E1..E32: multiply = shift-add of one multiplier bit; divide = restoring shift-subtract producing one quotient bit.
REQ-015 SHALL, at edge E33 (FIX), apply sign correction and write hi/lo; done=1 and busy=0 for the cycle following E33; latency start-to-done is exactly 33 cycles for every op.
REQ-016 SHALL assert busy from the cycle after E0 through the cycle ending at E33.
REQ-017 SHALL ignore start while busy=1; no operand or op capture, no restart.
REQ-018 SHALL accept a new start in the same cycle done=1 (back-to-back operation).
REQ-019 SHALL hold hi/lo at previous values during RUN; update only in FIX.
REQ-020 SHALL produce for MULT/MULTU the full 64-bit product {hi,lo}; signed product negated when operand signs differ.
REQ-021 SHALL truncate signed quotient toward zero; remainder takes the sign of the dividend.
REQ-022 SHALL, on divide by zero (rt_val=0, DIV or DIVU), still take full latency and return hi=rs_val, lo=32'hFFFF_FFFF.
REQ-023 SHALL return for DIV 0x8000_0000 / 0xFFFF_FFFF lo=0x8000_0000, hi=0 without special trap.
REQ-024 SHALL treat 0x8000_0000 magnitude as unsigned 2^31 internally (33-bit-safe, no overflow in magnitude path).

Reset
REQ-025 SHALL on reset force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, internal accumulators=0.
REQ-026 SHALL, on reset asserted mid-operation, abort with no done pulse and hi/lo=0 on the following cycle; reset has priority over start.

Structure
REQ-027 SHALL place op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), state encoding, WIDTH and iteration count (32) in shared package mdu_pkg.
REQ-028 SHALL use one sub-module mdu_sign_fix (conditional two's-complement negate, WIDTH bits) for operand magnitude and result correction; remaining datapath inline.

Verification
REQ-029 MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> done exactly 33 cycles after start edge, hi=0xFFFF_FFFE, lo=0x0000_0001.
REQ-030 MULT 0xFFFF_FFFD (-3) x 0x0000_0007 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (-21).
REQ-031 DIV 0xFFFF_FFF9 (-7) / 0x0000_0002 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); then DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
REQ-032 DIVU 0x0000_0064 / 0 -> after 33 cycles hi=0x0000_0064, lo=0xFFFF_FFFF, done pulse width 1.
REQ-033 DIVU 100/7 started; start with MULTU 2x3 pulsed at iteration 5 -> ignored, result hi=2, lo=14; MULTU 2x3 issued in done cycle -> hi=0, lo=6 after 33 more cycles.
REQ-034 MULT started, reset asserted at iteration 10 -> next cycle busy=0, done=0, hi=lo=0; no done pulse appears in the following 40 cycles.
